branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Execute-stage partner of the dual-issue F/D decoder and its branch predictor.
- Resolves BNE/BLT/BEX for the top and bottom issue slots against the predicted direction.
- Drives the predictor feedback bus consumed at decode: predictor_past_pc, predictor_past_wrong, past_predicted_taken, past_is_branch.
- Issues a multi-cycle front-end flush plus redirect PC on misprediction, and holds back a same-cycle bottom branch so that only one resolution is reported per cycle.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays high after a misprediction (>=1)
CNT_W, 16, width of saturating misprediction counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
valid_top  in  1  top slot holds a live instruction this cycle
instr_top  in  32  top-slot instruction (opcode [31:27], rd [26:22], rs [21:17], imm [16:0], T [26:0])
pc_top  in  32  address of top instruction
opA_top  in  32  value of $rs for top slot
opB_top  in  32  value of $rd for BNE/BLT, of $r31 for BEX, top slot
pred_taken_top  in  1  direction predicted at decode, top slot
valid_bot, instr_bot, pc_bot, opA_bot, opB_bot, pred_taken_bot  in  1/32/32/32/32/1  same fields for bottom slot
predictor_past_pc  out  32  PC of the reported resolved branch
predictor_past_wrong  out  1  reported branch was mispredicted
past_predicted_taken  out  1  prediction of the reported branch
past_is_branch  out  1  feedback bus valid
flush  out  1  squash F/D and D/X contents
redirect_pc  out  32  correct next PC, valid while flush=1
mispredict_count  out  CNT_W  saturating count of mispredictions

Behaviour:
- Decode of opcode [31:27]: BNE=00010, BLT=00110, BEX=10110. Any other opcode is a non-branch and is ignored.
- Taken rules:
  - BNE: opB != opA.
  - BLT: signed opB < opA, full 32-bit signed compare with no overflow error.
  - BEX: opB != 0.
- Targets, mod 2^32:
  - BNE/BLT taken target = pc+1+sign-extend(imm[16:0]).
  - BEX target = {5'b0,T}.
  - Not-taken target = pc+1.
- Wrong = actual_taken XOR pred_taken.
- All outputs are registered; feedback and flush appear one cycle after the resolving cycle.
- Reset (asynchronous): all outputs 0, state IDLE, hold buffer empty, counter 0.
- States:
  - IDLE:
    - Resolve top if it is a valid branch, else bot if it is a valid branch. Report on the feedback bus next cycle.
    - If both are valid branches: report top. If top is correct, capture bot into the hold buffer and go to HELD. If top is wrong, drop bot (wrong path).
    - Any reported mispredict goes to RECOVER.
  - HELD:
    - Report the buffered bot branch this cycle; slot inputs are not resolved in this cycle.
    - Next state: RECOVER if it was wrong, else IDLE.
  - RECOVER:
    - flush=1 and redirect_pc stable for exactly FLUSH_CYCLES cycles, beginning with the cycle predictor_past_wrong=1.
    - Slot inputs are ignored (wrong path); past_is_branch=0 after the first cycle.
    - Returns to IDLE after FLUSH_CYCLES.
- past_is_branch is high for exactly one cycle per resolved branch. When it is low, predictor_past_wrong and past_predicted_taken are 0.
- mispredict_count increments once per reported mispredict and saturates at all ones (no wrap).
- A reset asserted mid-RECOVER or mid-HELD drops flush and the buffered branch immediately.

Test Plan:
- BNE at pc=0x10, imm=0x5, opA=3, opB=4, pred=0 -> next cycle:
  - past_is_branch=1, past_wrong=1, past_pc=0x10.
  - flush=1 for 2 cycles, redirect_pc=0x16, mispredict_count=1.
- BLT opB=0xFFFFFFFF(-1), opA=1, pred=1, imm=0x1FFFE (-2), pc=0x20 -> taken, correct, feedback wrong=0, no flush.
- Both slots branches: top BEX opB=0, pred=0 (correct), bot BNE pc=0x31 mispredicted -> cycle+1 reports top; cycle+2 reports bot with wrong=1; flush starts cycle+2.
- Top mispredicted BLT plus bottom branch same cycle -> only top reported; bot never appears on the feedback bus; new branches inside flush window are ignored.
- Force CNT_W=2 and cause 5 mispredicts -> count reads 3 and stays.
- Assert reset during cycle 1 of RECOVER -> flush, past_is_branch and count drop to 0 asynchronously; a correct branch after reset release is reported with flush=0.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Slot-to-resolver and resolver-to-decode bus for the dual-issue branch resolver.
// master: drives the two issue slots and observes feedback/flush (execute-stage feeder / bench).
// slave : the branch_resolver itself, consuming slots and producing feedback/flush/redirect.
interface branch_resolver_if #(
    parameter int unsigned CNT_W = 16
);
    // Top issue slot
    logic        valid_top;
    logic [31:0] instr_top;
    logic [31:0] pc_top;
    logic [31:0] opA_top;
    logic [31:0] opB_top;
    logic        pred_taken_top;
    // Bottom issue slot
    logic        valid_bot;
    logic [31:0] instr_bot;
    logic [31:0] pc_bot;
    logic [31:0] opA_bot;
    logic [31:0] opB_bot;
    logic        pred_taken_bot;
    // Predictor feedback and front-end control
    logic [31:0]      predictor_past_pc;
    logic             predictor_past_wrong;
    logic             past_predicted_taken;
    logic             past_is_branch;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output valid_top, instr_top, pc_top, opA_top, opB_top, pred_taken_top,
        output valid_bot, instr_bot, pc_bot, opA_bot, opB_bot, pred_taken_bot,
        input  predictor_past_pc, predictor_past_wrong, past_predicted_taken,
        input  past_is_branch, flush, redirect_pc, mispredict_count
    );

    modport slave (
        input  valid_top, instr_top, pc_top, opA_top, opB_top, pred_taken_top,
        input  valid_bot, instr_bot, pc_bot, opA_bot, opB_bot, pred_taken_bot,
        output predictor_past_pc, predictor_past_wrong, past_predicted_taken,
        output past_is_branch, flush, redirect_pc, mispredict_count
    );
endinterface

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver for a dual-issue front end.
// Resolves BNE/BLT/BEX in the top and bottom slots against the decode-time
// prediction, reports one resolution per cycle on the predictor feedback bus,
// and raises a FLUSH_CYCLES-long flush with a redirect PC on a misprediction.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - branch_resolver_if.slave: slot inputs, feedback bus, flush,
//           redirect_pc and the saturating mispredict_count (CNT_W bits)
// All outputs are registered and appear one cycle after the resolving cycle.
module branch_resolver #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    branch_resolver_if.slave  bus
);

    localparam int unsigned REC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_BEX = 5'b10110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    // Fully resolved branch, also the format of the hold buffer
    typedef struct packed {
        logic        isBranch;
        logic        taken;
        logic        predTaken;
        logic        wrong;
        logic [31:0] pc;
        logic [31:0] target;
    } resolution_t;

    // Decode and resolve one slot
    function automatic resolution_t resolve(
        input logic        valid,
        input logic [31:0] instr,
        input logic [31:0] pc,
        input logic [31:0] opA,
        input logic [31:0] opB,
        input logic        pred
    );
        resolution_t r;
        logic [31:0] seqPc;
        logic [31:0] relTarget;
        seqPc     = pc + 32'd1;
        relTarget = seqPc + {{15{instr[16]}}, instr[16:0]};
        r           = '0;
        r.pc        = pc;
        r.predTaken = pred;
        r.target    = seqPc;
        case (instr[31:27])
            OP_BNE: begin
                r.isBranch = valid;
                r.taken    = (opB != opA);
                if (r.taken) r.target = relTarget;
            end
            OP_BLT: begin
                r.isBranch = valid;
                r.taken    = ($signed(opB) < $signed(opA));
                if (r.taken) r.target = relTarget;
            end
            OP_BEX: begin
                r.isBranch = valid;
                r.taken    = (opB != 32'd0);
                if (r.taken) r.target = {5'b0, instr[26:0]};
            end
            default: r.isBranch = 1'b0;
        endcase
        r.wrong = r.taken ^ pred;
        return r;
    endfunction

    state_t           state, stateNext;
    logic [REC_W-1:0] recoverCnt, recoverCntNext;
    resolution_t      hold, holdNext;
    logic [31:0]      pastPc, pastPcNext;
    logic             pastWrong, pastWrongNext;
    logic             pastPred, pastPredNext;
    logic             pastIsBranch, pastIsBranchNext;
    logic             flushQ, flushNext;
    logic [31:0]      redirectPc, redirectNext;
    logic [CNT_W-1:0] count, countNext;

    resolution_t topRes;
    resolution_t botRes;
    resolution_t report;
    logic        doReport;

    assign topRes = resolve(bus.valid_top, bus.instr_top, bus.pc_top,
                            bus.opA_top, bus.opB_top, bus.pred_taken_top);
    assign botRes = resolve(bus.valid_bot, bus.instr_bot, bus.pc_bot,
                            bus.opA_bot, bus.opB_bot, bus.pred_taken_bot);

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            recoverCnt   <= '0;
            hold         <= '0;
            pastPc       <= '0;
            pastWrong    <= 1'b0;
            pastPred     <= 1'b0;
            pastIsBranch <= 1'b0;
            flushQ       <= 1'b0;
            redirectPc   <= '0;
            count        <= '0;
        end else begin
            state        <= stateNext;
            recoverCnt   <= recoverCntNext;
            hold         <= holdNext;
            pastPc       <= pastPcNext;
            pastWrong    <= pastWrongNext;
            pastPred     <= pastPredNext;
            pastIsBranch <= pastIsBranchNext;
            flushQ       <= flushNext;
            redirectPc   <= redirectNext;
            count        <= countNext;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext        = state;
        recoverCntNext   = recoverCnt;
        holdNext         = hold;
        pastPcNext       = pastPc;
        pastWrongNext    = 1'b0;
        pastPredNext     = 1'b0;
        pastIsBranchNext = 1'b0;
        flushNext        = 1'b0;
        redirectNext     = redirectPc;
        countNext        = count;
        report           = '0;
        doReport         = 1'b0;

        case (state)
            IDLE: begin
                if (topRes.isBranch) begin
                    report   = topRes;
                    doReport = 1'b1;
                    // Bottom branch is only on the correct path if top was predicted right
                    if (botRes.isBranch && !topRes.wrong) begin
                        holdNext  = botRes;
                        stateNext = HELD;
                    end
                end else if (botRes.isBranch) begin
                    report   = botRes;
                    doReport = 1'b1;
                end
            end
            HELD: begin
                report    = hold;
                doReport  = 1'b1;
                holdNext  = '0;
                stateNext = IDLE;
            end
            RECOVER: begin
                // Flush was raised together with the report; this counts the remaining cycles
                if (recoverCnt == REC_W'(FLUSH_CYCLES - 1)) begin
                    recoverCntNext = '0;
                    stateNext      = IDLE;
                end else begin
                    recoverCntNext = recoverCnt + REC_W'(1);
                    flushNext      = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (doReport) begin
            pastIsBranchNext = 1'b1;
            pastPcNext       = report.pc;
            pastWrongNext    = report.wrong;
            pastPredNext     = report.predTaken;
            if (report.wrong) begin
                flushNext      = 1'b1;
                redirectNext   = report.target;
                stateNext      = RECOVER;
                recoverCntNext = '0;
                if (count != {CNT_W{1'b1}}) countNext = count + CNT_W'(1);
            end
        end
    end

    assign bus.predictor_past_pc    = pastPc;
    assign bus.predictor_past_wrong = pastWrong;
    assign bus.past_predicted_taken = pastPred;
    assign bus.past_is_branch       = pastIsBranch;
    assign bus.flush                = flushQ;
    assign bus.redirect_pc          = redirectPc;
    assign bus.mispredict_count     = count;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios plus random slot traffic,
// checked cycle by cycle against a queue-based behavioural model.
module tb_branch_resolver;

    localparam int unsigned FLUSH   = 2;
    localparam int unsigned CNT_BIG = 16;
    localparam int unsigned CNT_SML = 2;

    localparam logic [4:0] BNE = 5'b00010;
    localparam logic [4:0] BLT = 5'b00110;
    localparam logic [4:0] BEX = 5'b10110;
    localparam logic [4:0] ADD = 5'b00000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    branch_resolver_if #(.CNT_W(CNT_BIG)) bus ();
    branch_resolver_if #(.CNT_W(CNT_SML)) busS ();

    // Small-counter instance sees exactly the same slot traffic
    assign busS.valid_top      = bus.valid_top;
    assign busS.instr_top      = bus.instr_top;
    assign busS.pc_top         = bus.pc_top;
    assign busS.opA_top        = bus.opA_top;
    assign busS.opB_top        = bus.opB_top;
    assign busS.pred_taken_top = bus.pred_taken_top;
    assign busS.valid_bot      = bus.valid_bot;
    assign busS.instr_bot      = bus.instr_bot;
    assign busS.pc_bot         = bus.pc_bot;
    assign busS.opA_bot        = bus.opA_bot;
    assign busS.opB_bot        = bus.opB_bot;
    assign busS.pred_taken_bot = bus.pred_taken_bot;

    branch_resolver #(.FLUSH_CYCLES(FLUSH), .CNT_W(CNT_BIG)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    branch_resolver #(.FLUSH_CYCLES(FLUSH), .CNT_W(CNT_SML)) dutS (
        .clock(clock), .reset(reset), .bus(busS)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit          br;
        bit          pred;
        bit          wrong;
        logic [31:0] pc;
        logic [31:0] target;
    } res_t;

    res_t        pend[$];
    int          flushLeft;
    int          misp;
    bit          expPib, expWrong, expPred, expFlush;
    logic [31:0] expPc, expRedirect;

    function automatic res_t modelResolve(input bit v, input logic [31:0] instr,
                                          input logic [31:0] pc, input logic [31:0] a,
                                          input logic [31:0] b, input bit pred);
        res_t r;
        logic [4:0]  op;
        logic [16:0] imm;
        int          off;
        bit          taken;
        op    = instr[31:27];
        imm   = instr[16:0];
        off   = int'(imm);
        if (imm >= 17'h10000) off = off - 131072;
        taken = 1'b0;
        r.br  = v && (op == BNE || op == BLT || op == BEX);
        r.pc  = pc;
        r.pred = pred;
        r.target = pc + 32'd1;
        if (op == BNE) taken = (a != b);
        if (op == BLT) taken = (int'(b) < int'(a));
        if (op == BEX) taken = (b != 32'd0);
        if (taken && op == BEX) r.target = 32'(instr[26:0]);
        else if (taken)         r.target = pc + 32'd1 + 32'(off);
        r.wrong = (taken != pred);
        return r;
    endfunction

    task automatic modelReset();
        pend.delete();
        flushLeft = 0; misp = 0;
        expPib = 0; expWrong = 0; expPred = 0; expFlush = 0;
        expPc = '0; expRedirect = '0;
    endtask

    task automatic modelReport(input res_t r);
        expPib   = 1'b1;
        expPc    = r.pc;
        expWrong = r.wrong;
        expPred  = r.pred;
        expFlush = r.wrong;
        if (r.wrong) begin
            misp++;
            expRedirect = r.target;
            flushLeft   = FLUSH;
        end
    endtask

    // Expected outputs after the coming clock edge, given current slot inputs
    task automatic modelStep();
        res_t t, b;
        expPib = 0; expWrong = 0; expPred = 0; expFlush = 0;
        if (flushLeft > 0) begin
            flushLeft--;
            expFlush = (flushLeft > 0);
        end else if (pend.size() > 0) begin
            modelReport(pend.pop_front());
        end else begin
            t = modelResolve(bus.valid_top, bus.instr_top, bus.pc_top, bus.opA_top,
                             bus.opB_top, bus.pred_taken_top);
            b = modelResolve(bus.valid_bot, bus.instr_bot, bus.pc_bot, bus.opA_bot,
                             bus.opB_bot, bus.pred_taken_bot);
            if (t.br) begin
                modelReport(t);
                if (b.br && !t.wrong) pend.push_back(b);
            end else if (b.br) begin
                modelReport(b);
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        int big, sml;
        big = (misp > 65535) ? 65535 : misp;
        sml = (misp > 3) ? 3 : misp;
        check({tag, "_pib"},   32'(bus.past_is_branch),       32'(expPib));
        check({tag, "_wrong"}, 32'(bus.predictor_past_wrong), 32'(expWrong));
        check({tag, "_pred"},  32'(bus.past_predicted_taken), 32'(expPred));
        check({tag, "_flush"}, 32'(bus.flush),                32'(expFlush));
        check({tag, "_cnt"},   32'(bus.mispredict_count),     32'(big));
        check({tag, "_cntS"},  32'(busS.mispredict_count),    32'(sml));
        check({tag, "_flushS"}, 32'(busS.flush),              32'(expFlush));
        if (expPib)   check({tag, "_pc"},  bus.predictor_past_pc, expPc);
        if (expFlush) check({tag, "_rdr"}, bus.redirect_pc,       expRedirect);
    endtask

    task automatic tick(input string tag);
        modelStep();
        @(posedge clock);
        #1;
        checkAll(tag);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [26:0] low);
        return {op, low};
    endfunction

    task automatic drive(input bit vt, input logic [31:0] it, input logic [31:0] pt,
                         input logic [31:0] at, input logic [31:0] bt, input bit prt,
                         input bit vb, input logic [31:0] ib, input logic [31:0] pb,
                         input logic [31:0] ab, input logic [31:0] bb, input bit prb);
        bus.valid_top = vt; bus.instr_top = it; bus.pc_top = pt;
        bus.opA_top = at; bus.opB_top = bt; bus.pred_taken_top = prt;
        bus.valid_bot = vb; bus.instr_bot = ib; bus.pc_bot = pb;
        bus.opA_bot = ab; bus.opB_bot = bb; bus.pred_taken_bot = prb;
    endtask

    task automatic idleSlots();
        drive(0, '0, '0, '0, '0, 0, 0, '0, '0, '0, '0, 0);
    endtask

    function automatic logic [31:0] randInstr();
        logic [4:0] op;
        case ($urandom_range(0, 3))
            0: op = BNE;
            1: op = BLT;
            2: op = BEX;
            default: op = ADD;
        endcase
        return mk(op, 27'($urandom));
    endfunction

    function automatic logic [31:0] randOp();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return 32'($urandom_range(0, 4));
            2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] a, b, c, d;
        reset = 1'b1;
        idleSlots();
        modelReset();
        #12;
        checkAll("reset");
        @(negedge clock);
        reset = 1'b0;

        // BNE mispredicted not-taken
        drive(1, mk(BNE, 27'h5), 32'h10, 32'd3, 32'd4, 0, 0, '0, '0, '0, '0, 0);
        tick("bne_wrong");
        check("tp1_pc", bus.predictor_past_pc, 32'h10);
        check("tp1_rdr", bus.redirect_pc, 32'h16);
        check("tp1_cnt", 32'(bus.mispredict_count), 32'd1);
        idleSlots();
        tick("bne_flush2");
        check("tp1_flush2", 32'(bus.flush), 32'd1);
        tick("bne_done");
        check("tp1_flush_off", 32'(bus.flush), 32'd0);

        // BLT with -1 < 1, negative offset, predicted taken
        drive(1, mk(BLT, 27'h1FFFE), 32'h20, 32'd1, 32'hFFFF_FFFF, 1, 0, '0, '0, '0, '0, 0);
        tick("blt_ok");
        check("tp2_wrong", 32'(bus.predictor_past_wrong), 32'd0);
        check("tp2_flush", 32'(bus.flush), 32'd0);
        idleSlots();
        tick("blt_idle");

        // Both slots: top correct BEX, bottom mispredicted BNE gets held
        drive(1, mk(BEX, 27'h100), 32'h30, 32'd9, 32'd0, 0,
              1, mk(BNE, 27'h3), 32'h31, 32'd1, 32'd2, 0);
        tick("both_top");
        check("tp3_top_pc", bus.predictor_past_pc, 32'h30);
        // Branch presented during HELD must be ignored
        drive(1, mk(BNE, 27'h7), 32'h50, 32'd1, 32'd2, 0, 0, '0, '0, '0, '0, 0);
        tick("both_bot");
        check("tp3_bot_pc", bus.predictor_past_pc, 32'h31);
        check("tp3_bot_wrong", 32'(bus.predictor_past_wrong), 32'd1);
        check("tp3_rdr", bus.redirect_pc, 32'h35);
        idleSlots();
        tick("both_fl2");
        tick("both_done");

        // Top mispredicted BLT drops same-cycle bottom branch; flush window ignores slots
        drive(1, mk(BLT, 27'h4), 32'h40, 32'd5, 32'd2, 0,
              1, mk(BNE, 27'h2), 32'h41, 32'd1, 32'd2, 0);
        tick("drop_top");
        check("tp4_pc", bus.predictor_past_pc, 32'h40);
        drive(1, mk(BNE, 27'h2), 32'h60, 32'd1, 32'd2, 0,
              1, mk(BEX, 27'h9), 32'h61, 32'd0, 32'd1, 0);
        tick("drop_fl2");
        check("tp4_no_bot", 32'(bus.past_is_branch), 32'd0);
        tick("drop_fl_end");
        idleSlots();
        tick("drop_idle");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            a = randOp(); b = randOp(); c = randOp(); d = randOp();
            if ($urandom_range(0, 2) == 0) b = a;
            if ($urandom_range(0, 2) == 0) d = c;
            drive($urandom_range(0, 3) != 0, randInstr(), 32'($urandom), a, b, 1'($urandom),
                  $urandom_range(0, 3) != 0, randInstr(), 32'($urandom), c, d, 1'($urandom));
            tick($sformatf("rnd%0d", i));
        end
        if (misp >= 5) check("sat_small", 32'(busS.mispredict_count), 32'd3);

        // Drain, then reset during the first RECOVER cycle
        idleSlots();
        for (int i = 0; i < 4; i++) tick("drain");
        drive(1, mk(BNE, 27'h8), 32'h70, 32'd1, 32'd2, 0, 0, '0, '0, '0, '0, 0);
        tick("pre_rst");
        idleSlots();
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll("mid_rst");
        check("rst_flush", 32'(bus.flush), 32'd0);
        check("rst_cnt", 32'(bus.mispredict_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(1, mk(BNE, 27'h8), 32'h80, 32'd7, 32'd7, 0, 0, '0, '0, '0, '0, 0);
        tick("post_rst");
        check("post_rst_pib", 32'(bus.past_is_branch), 32'd1);
        check("post_rst_flush", 32'(bus.flush), 32'd0);
        idleSlots();
        tick("post_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
